wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-precision add/subtract sequencer. It time-shares one sixteenBitCLA instance over WORDS consecutive cycles to produce a 16*WORDS-bit result.
- Carry is chained between words through a flop, one 16-bit slice per cycle.
- Sits beside the execute stage for wide arithmetic: address and accumulator math that exceeds the 16-bit datapath.
- Start/done/ack handshake toward the issuing control logic.

Parameters:
- WORDS, 2, number of 16-bit slices per operation; legal values 1 to 4; operand width W = 16*WORDS.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new operation; accepted only in IDLE, or in DONE when ack=1
- sub  input  1  0 = A+B, 1 = A-B
- cin  input  1  carry-in for add; borrow-in for sub
- A  input  W  operand A, sampled on accept
- B  input  W  operand B, sampled on accept
- ack  input  1  consumer has taken the result
- busy  output  1  high in RUN and DONE
- done  output  1  high in DONE; result outputs valid
- sum  output  W  result
- cout  output  1  carry out of the top slice; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset: state=IDLE, idx=0, carry_reg=0, sum=0, cout=0, ovf=0, zero=0, busy=0, done=0. Reset overrides every other input on the same edge.
- Reset mid-RUN or in DONE: return to IDLE, discard the partial result, clear all outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches A, B and sub into internal registers.
  - carry_reg <= cin ^ sub. With sub=1, cin=0 this gives the +1 of two's complement; cin=1 subtracts an extra 1.
  - idx <= 0; next state RUN.
- RUN, each cycle:
  - Adder inputs: A_lat[16*idx +: 16] and B_lat[16*idx +: 16] ^ {16{sub_lat}}, with C0 = carry_reg.
  - Adder Out is written to sum[16*idx +: 16]; carry_reg <= C16.
  - While idx < WORDS-1: idx <= idx+1.
  - At idx == WORDS-1, go to DONE and register the flags:
    - cout = C16 of the top slice.
    - ovf = (A_lat[W-1] == Beff[W-1]) & (top Out[15] != A_lat[W-1]), where Beff = B_lat ^ {W{sub_lat}}.
    - zero = (final sum == 0), including the top slice just written.
- Outputs are registered. sum bits not yet written in RUN hold their previous-operation value and are don't-care until done.
- DONE:
  - done=1; sum and flags held stable.
  - ack=1, start=0: go to IDLE next cycle.
  - ack=1, start=1: accept the new operation and go directly to RUN (back-to-back, no IDLE bubble).
  - ack=0: hold, regardless of start.
- start while in RUN, or in DONE without ack, is ignored. No queuing.
- ack outside DONE is ignored.
- Latency: accept on edge t; RUN occupies edges t+1 .. t+WORDS; done is high from the cycle after edge t+WORDS. WORDS=2 gives done visible 3 cycles after start is sampled. Throughput is one operation per WORDS+1 cycles with back-to-back ack+start.
- A and B may change after accept without affecting the operation in flight.
- The sixteenBitCLA P, G and C12 outputs are unused.

Test Plan:
- WORDS=2: A=0x0000FFFF, B=0x00000001, sub=0, cin=0 -> sum=0x00010000, cout=0, ovf=0, zero=0; done high 3 cycles after start is sampled.
- WORDS=2: A=0x00000000, B=0x00000001, sub=1, cin=0 -> sum=0xFFFFFFFF, cout=0 (borrow), ovf=0. Then A=B=0x12345678, sub=1 -> sum=0, zero=1, cout=1.
- WORDS=2: A=0x7FFFFFFF, B=0x00000001, add -> sum=0x80000000, ovf=1, cout=0. Then A=0xFFFFFFFF, B=0x00000001 -> sum=0, cout=1, zero=1, ovf=0.
- Pulse start with new operands during RUN and during DONE with ack=0 -> ignored; the original result is unchanged and done stays high until ack.
- Assert rst on the first RUN cycle -> next cycle busy=0, done=0, sum=0. A fresh start then completes normally with the correct result.
- In DONE, drive ack=1 and start=1 together with A=0x00010000, B=0x0000FFFF, add -> no IDLE cycle; busy stays high; done reasserts after WORDS RUN cycles with sum=0x0001FFFF. Repeat with WORDS=1 and WORDS=4 on carry-propagating values, e.g. WORDS=4, A=0x0000FFFFFFFFFFFF, B=1 -> sum=0x0001000000000000.

Source files
------------

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-word add/subtract that reuses one 16-bit carry-lookahead adder,
// one slice per cycle, with the inter-slice carry held in a flop.
module sixteenBitCLA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C0,
    output logic [15:0] Out,
    output logic        P,
    output logic        G,
    output logic        C12,
    output logic        C16
);
    logic [15:0] w_p, w_g, w_c;
    logic [3:0]  w_gp, w_gg;
    logic [4:0]  w_gc;
    assign w_p = A ^ B;
    assign w_g = A & B;
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : grp
            assign w_gp[k] = &w_p[4*k +: 4];
            assign w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                           | ((&w_p[4*k+2 +: 2]) & w_g[4*k+1])
                           | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
            assign w_c[4*k]   = w_gc[k];
            assign w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            assign w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                              | ((&w_p[4*k +: 2]) & w_gc[k]);
            assign w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                              | ((&w_p[4*k+1 +: 2]) & w_g[4*k])
                              | ((&w_p[4*k +: 3]) & w_gc[k]);
        end
    endgenerate
    // Second lookahead level across the four 4-bit groups
    assign w_gc[0] = C0;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & C0);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | ((&w_gp[1:0]) & C0);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | ((&w_gp[2:1]) & w_gg[0])
                   | ((&w_gp[2:0]) & C0);
    assign G = w_gg[3] | (w_gp[3] & w_gg[2]) | ((&w_gp[3:2]) & w_gg[1])
             | ((&w_gp[3:1]) & w_gg[0]);
    assign P   = &w_gp;
    assign w_gc[4] = G | (P & C0);
    assign C12 = w_gc[3];
    assign C16 = w_gc[4];
    assign Out = w_p ^ w_c;
endmodule

module wide_add_seq #(
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [16*WORDS-1:0]  A,
    input  logic [16*WORDS-1:0]  B,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        r_state, w_next;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a, r_b, w_sum;
    logic          r_sub, r_carry;
    logic [15:0]   w_out;
    logic          w_c16, w_accept, w_last;
    logic          w_unused_p, w_unused_g, w_unused_c12;
    assign w_accept = start & ((r_state == IDLE) | ((r_state == DONE) & ack));
    assign w_last   = (r_state == RUN) & (r_idx == IW'(WORDS - 1));
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    // Subtraction inverts B per slice; the +1 enters through the initial carry
    sixteenBitCLA u_cla (
        .A   (r_a[16*r_idx +: 16]),
        .B   (r_b[16*r_idx +: 16] ^ {16{r_sub}}),
        .C0  (r_carry),
        .Out (w_out),
        .P   (w_unused_p),
        .G   (w_unused_g),
        .C12 (w_unused_c12),
        .C16 (w_c16)
    );
    always_comb begin
        w_next = w_accept ? RUN : w_last ? DONE : ((r_state == DONE) & ack) ? IDLE : r_state;
        w_sum = sum;
        w_sum[16*r_idx +: 16] = w_out;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= B;
                r_sub   <= sub;
                r_carry <= cin ^ sub;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                sum     <= w_sum;
                r_carry <= w_c16;
                r_idx   <= w_last ? r_idx : r_idx + 1'b1;
                if (w_last) begin
                    cout <= w_c16;
                    ovf  <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) & (w_out[15] != r_a[W-1]);
                    zero <= (w_sum == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed vectors against WORDS=1, 2 and 4 instances,
// plus hand sequences for ignored starts and reset during RUN.
module tb_wide_add_seq;
    logic        clk = 1'b0, rst = 1'b1, sub = 1'b0, cin = 1'b0, ack = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0, s4 = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic        busy4, done4, cout4, ovf4, zero4;
    logic [15:0] sum1;
    logic [31:0] sum2;
    logic [63:0] sum4;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        logic [63:0] a, b;
        logic        sub, cin;
        int          w;
        logic        b2b;
        logic [63:0] s;
        logic        c, v, z;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    wide_add_seq #(.WORDS(1)) u1 (.clk(clk), .rst(rst), .start(s1), .sub(sub), .cin(cin),
        .A(a[15:0]), .B(b[15:0]), .ack(ack), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .zero(zero1));
    wide_add_seq #(.WORDS(2)) u2 (.clk(clk), .rst(rst), .start(s2), .sub(sub), .cin(cin),
        .A(a[31:0]), .B(b[31:0]), .ack(ack), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2), .zero(zero2));
    wide_add_seq #(.WORDS(4)) u4 (.clk(clk), .rst(rst), .start(s4), .sub(sub), .cin(cin),
        .A(a), .B(b), .ack(ack), .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .zero(zero4));

    function automatic logic f_busy(int w);
        return (w == 1) ? busy1 : (w == 2) ? busy2 : busy4;
    endfunction
    function automatic logic f_done(int w);
        return (w == 1) ? done1 : (w == 2) ? done2 : done4;
    endfunction
    function automatic logic [63:0] f_sum(int w);
        return (w == 1) ? {48'h0, sum1} : (w == 2) ? {32'h0, sum2} : sum4;
    endfunction
    function automatic logic [2:0] f_flags(int w);
        return (w == 1) ? {cout1, ovf1, zero1} : (w == 2) ? {cout2, ovf2, zero2} : {cout4, ovf4, zero4};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_start(int w, logic v);
        s1 = v & (w == 1);
        s2 = v & (w == 2);
        s4 = v & (w == 4);
    endtask

    task automatic run_op(vec_t v, int k);
        int cnt;
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; cin = v.cin; ack = v.b2b;
        set_start(v.w, 1'b1);
        @(negedge clk);
        set_start(v.w, 1'b0);
        ack = 1'b0; a = ~v.a; b = ~v.b; sub = ~v.sub; cin = ~v.cin;
        chk($sformatf("v%0d busy_after_accept", k), 64'(f_busy(v.w)), 64'd1);
        chk($sformatf("v%0d done_after_accept", k), 64'(f_done(v.w)), 64'd0);
        cnt = 1;
        while (!f_done(v.w) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("v%0d latency", k), 64'(cnt), 64'(v.w + 1));
        chk($sformatf("v%0d sum", k), f_sum(v.w), v.s);
        chk($sformatf("v%0d cout_ovf_zero", k), 64'(f_flags(v.w)), 64'({v.c, v.v, v.z}));
    endtask

    task automatic go_idle(int w, int k);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk($sformatf("v%0d idle_busy_done", k), 64'({f_busy(w), f_done(w)}), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{64'h0000FFFF, 64'h1, 1'b0, 1'b0, 2, 1'b0, 64'h00010000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{64'h0, 64'h1, 1'b1, 1'b0, 2, 1'b0, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{64'h12345678, 64'h12345678, 1'b1, 1'b0, 2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 2, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{64'h1, 64'h2, 1'b0, 1'b1, 2, 1'b0, 64'h4, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{64'h10, 64'h3, 1'b1, 1'b1, 2, 1'b0, 64'hC, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{64'h80000000, 64'h1, 1'b1, 1'b0, 2, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{64'h00010000, 64'h0000FFFF, 1'b0, 1'b0, 2, 1'b1, 64'h0001FFFF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{64'hFFFF, 64'h1, 1'b0, 1'b0, 1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{64'h7FFF, 64'h1, 1'b0, 1'b0, 1, 1'b1, 64'h8000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{64'h5, 64'h7, 1'b1, 1'b0, 1, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{64'h1, 64'h2, 1'b0, 1'b0, 4, 1'b0, 64'h3, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{64'h0000FFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 4, 1'b1, 64'h0001000000000000, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 4, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{64'h0, 64'h1, 1'b1, 1'b0, 4, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_w2", {busy2, done2, sum2, cout2, ovf2, zero2}, 64'd0);
        chk("reset_w1_w4", {busy1, done1, busy4, done4, sum1}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], i);
            if (i == 15 || !tbl[i+1].b2b)
                go_idle(tbl[i].w, i);
        end

        // start pulses during RUN and during DONE without ack are ignored
        @(negedge clk);
        a = 64'h0000FFFF; b = 64'h1; sub = 1'b0; cin = 1'b0; s2 = 1'b1;
        @(negedge clk);
        a = 64'h0; b = 64'h5; sub = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        @(negedge clk);
        chk("ign_done", 64'(done2), 64'd1);
        chk("ign_sum", 64'(sum2), 64'h00010000);
        s2 = 1'b1; a = 64'h22; b = 64'h33; sub = 1'b0;
        repeat (2) @(negedge clk);
        s2 = 1'b0;
        chk("ign_done_hold", 64'({busy2, done2}), 64'd3);
        chk("ign_sum_hold", 64'(sum2), 64'h00010000);
        chk("ign_flags_hold", 64'({cout2, ovf2, zero2}), 64'd0);
        go_idle(2, 100);

        // reset on the first RUN cycle
        @(negedge clk);
        a = 64'h3; b = 64'h4; sub = 1'b0; cin = 1'b0; s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run_state", 64'({busy2, done2}), 64'd0);
        chk("rst_run_sum", 64'(sum2), 64'd0);
        run_op('{64'h3, 64'h4, 1'b0, 1'b0, 2, 1'b0, 64'h7, 1'b0, 1'b0, 1'b0}, 101);
        go_idle(2, 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
